// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: state encodings, legal oversampling ratios, frame bit indices and the
// strobe bundle shared by the UART receive frame sequencer.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_OUT    = 3'd5
   } rx_state_e;

   localparam int PRESC_8X  = 7;
   localparam int PRESC_16X = 15;
   localparam int PRESC_32X = 31;

   localparam logic [3:0] START_BIT = 4'd0;
   localparam logic [3:0] LAST_DATA = 4'd8;

   typedef struct packed {
      logic samp;
      logic deser;
      logic strt_chk;
      logic par_chk;
      logic stp_chk;
      logic valid;
   } rx_ctrl_t;

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// uart_rx_edge_bit_cnt: oversampling edge counter (0..prescale) and frame bit counter.
// clear together with count_en restarts at edge 1, used when the OUT cycle already spent edge 0.
module uart_rx_edge_bit_cnt
   import uart_rx_pkg::*;
#(
   parameter int PRESCALE_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  count_en,
   input  logic                  clear,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic [PRESCALE_W-1:0] edge_cnt,
   output logic [3:0]            bit_cnt,
   output logic [PRESCALE_W-1:0] edge_nxt
);

   logic [3:0] bit_nxt_s;

   // next edge/bit count
   always_comb begin
      edge_nxt  = edge_cnt;
      bit_nxt_s = bit_cnt;
      if (clear) begin
         edge_nxt  = count_en ? PRESCALE_W'(1) : PRESCALE_W'(0);
         bit_nxt_s = START_BIT;
      end else if (count_en) begin
         if (edge_cnt == prescale) begin
            edge_nxt  = PRESCALE_W'(0);
            bit_nxt_s = bit_cnt + 4'd1;
         end else begin
            edge_nxt  = edge_cnt + PRESCALE_W'(1);
            bit_nxt_s = bit_cnt;
         end
      end else begin
         edge_nxt  = edge_cnt;
         bit_nxt_s = bit_cnt;
      end
   end

   // counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         edge_cnt <= PRESCALE_W'(0);
         bit_cnt  <= START_BIT;
      end else begin
         edge_cnt <= edge_nxt;
         bit_cnt  <= bit_nxt_s;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame sequencer (start detect, bit timing, checker strobes, data_valid).
// Build macro UART_RX_ERR_CNT_EN adds saturating parity/stop abort counters.
module uart_rx_ctrl
   import uart_rx_pkg::*;
#(
   parameter int PRESCALE_W = 5,
   parameter int DATA_W     = int'(LAST_DATA)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_in,
   input  logic                  par_en,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  strt_glitch,
   input  logic                  par_err,
   input  logic                  stp_err,
   output logic [PRESCALE_W-1:0] edge_cnt,
   output logic [3:0]            bit_cnt,
   output logic                  dat_samp_en,
   output logic                  deser_en,
   output logic                  strt_chk_en,
   output logic                  par_chk_en,
   output logic                  stp_chk_en,
`ifdef UART_RX_ERR_CNT_EN
   output logic [7:0]            par_err_cnt,
   output logic [7:0]            stp_err_cnt,
`endif
   output logic                  data_valid
);

   rx_state_e             state_r, state_s;
   logic [PRESCALE_W-1:0] presc_r, presc_s;
   rx_ctrl_t              ctrl_r, ctrl_s;
   logic                  count_en_s, clear_s;
   logic [PRESCALE_W-1:0] edge_nxt_s;

   function automatic logic [PRESCALE_W-1:0] legal_prescale(input logic [PRESCALE_W-1:0] p);
      if (p == PRESCALE_W'(PRESC_16X) || p == PRESCALE_W'(PRESC_32X)) begin
         return p;
      end else begin
         return PRESCALE_W'(PRESC_8X);
      end
   endfunction

   function automatic rx_ctrl_t decode(input rx_state_e st, input logic [PRESCALE_W-1:0] e,
                                       input logic [PRESCALE_W-1:0] p);
      rx_ctrl_t c;
      logic     last;
      last       = (e == p);
      c.samp     = (st == ST_START) || (st == ST_DATA) || (st == ST_PARITY) || (st == ST_STOP);
      c.strt_chk = (st == ST_START) && last;
      c.deser    = (st == ST_DATA) && last;
      c.par_chk  = (st == ST_PARITY) && last;
      c.stp_chk  = (st == ST_STOP) && last;
      c.valid    = (st == ST_OUT);
      return c;
   endfunction

   uart_rx_edge_bit_cnt #(.PRESCALE_W(PRESCALE_W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .count_en (count_en_s),
      .clear    (clear_s),
      .prescale (presc_r),
      .edge_cnt (edge_cnt),
      .bit_cnt  (bit_cnt),
      .edge_nxt (edge_nxt_s)
   );

   // next-state: checker flags only matter in the cycle their registered strobe is high
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE:   state_s = rx_in ? ST_IDLE : ST_START;
         ST_START: begin
            if (ctrl_r.strt_chk) state_s = strt_glitch ? ST_IDLE : ST_DATA;
            else                 state_s = ST_START;
         end
         ST_DATA: begin
            if (ctrl_r.deser && (bit_cnt == 4'(DATA_W))) state_s = par_en ? ST_PARITY : ST_STOP;
            else                                         state_s = ST_DATA;
         end
         ST_PARITY: begin
            if (ctrl_r.par_chk) state_s = par_err ? ST_IDLE : ST_STOP;
            else                state_s = ST_PARITY;
         end
         ST_STOP: begin
            if (ctrl_r.stp_chk) state_s = stp_err ? ST_IDLE : ST_OUT;
            else                state_s = ST_STOP;
         end
         ST_OUT:    state_s = rx_in ? ST_IDLE : ST_START;
         default:   state_s = ST_IDLE;
      endcase
   end

   // counter control, prescale latch and look-ahead strobe decode
   always_comb begin
      clear_s    = (state_s == ST_IDLE) || (state_s == ST_OUT) ||
                   (state_r == ST_IDLE) || (state_r == ST_OUT);
      count_en_s = (state_s != ST_IDLE) && (state_s != ST_OUT) && (state_r != ST_IDLE);
      if ((state_s == ST_START) && (state_r != ST_START)) begin
         presc_s = legal_prescale(prescale);
      end else begin
         presc_s = presc_r;
      end
      ctrl_s = decode(state_s, edge_nxt_s, presc_s);
   end

   // state, latched prescale and registered strobes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         presc_r <= PRESCALE_W'(PRESC_8X);
         ctrl_r  <= '0;
      end else begin
         state_r <= state_s;
         presc_r <= presc_s;
         ctrl_r  <= ctrl_s;
      end
   end

   assign dat_samp_en = ctrl_r.samp;
   assign deser_en    = ctrl_r.deser;
   assign strt_chk_en = ctrl_r.strt_chk;
   assign par_chk_en  = ctrl_r.par_chk;
   assign stp_chk_en  = ctrl_r.stp_chk;
   assign data_valid  = ctrl_r.valid;

`ifdef UART_RX_ERR_CNT_EN
   logic [7:0] par_cnt_r, stp_cnt_r;

   // saturating abort counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         par_cnt_r <= 8'd0;
         stp_cnt_r <= 8'd0;
      end else begin
         if (ctrl_r.par_chk && par_err && (par_cnt_r != 8'hFF)) par_cnt_r <= par_cnt_r + 8'd1;
         if (ctrl_r.stp_chk && stp_err && (stp_cnt_r != 8'hFF)) stp_cnt_r <= stp_cnt_r + 8'd1;
      end
   end

   assign par_err_cnt = par_cnt_r;
   assign stp_err_cnt = stp_cnt_r;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed UART frames; expected strobe/data_valid events are queued when a frame
// is issued and a negedge monitor pops and compares them whenever the DUT raises an output.
module tb_uart_rx_ctrl;

   logic       clk = 1'b0;
   logic       rst, rx_in, par_en, strt_glitch, par_err, stp_err;
   logic [4:0] prescale;
   logic [4:0] edge_cnt;
   logic [3:0] bit_cnt;
   logic       dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid;
`ifdef UART_RX_ERR_CNT_EN
   logic [7:0] par_err_cnt, stp_err_cnt;
`endif

   typedef struct {
      int kind;
      int at;
      int edge_v;
      int bit_v;
      int samp;
   } ev_t;

   ev_t exp_q[$];
   int  cyc    = 0;
   int  checks = 0;
   int  errors = 0;

   uart_rx_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .rx_in       (rx_in),
      .par_en      (par_en),
      .prescale    (prescale),
      .strt_glitch (strt_glitch),
      .par_err     (par_err),
      .stp_err     (stp_err),
      .edge_cnt    (edge_cnt),
      .bit_cnt     (bit_cnt),
      .dat_samp_en (dat_samp_en),
      .deser_en    (deser_en),
      .strt_chk_en (strt_chk_en),
      .par_chk_en  (par_chk_en),
      .stp_chk_en  (stp_chk_en),
`ifdef UART_RX_ERR_CNT_EN
      .par_err_cnt (par_err_cnt),
      .stp_err_cnt (stp_err_cnt),
`endif
      .data_valid  (data_valid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic expect_ev(input int kind, input int at, input int ev, input int bv, input int sp);
      ev_t e;
      e.kind = kind; e.at = at; e.edge_v = ev; e.bit_v = bv; e.samp = sp;
      exp_q.push_back(e);
   endtask

   // kinds: 0 strt_chk, 1 deser, 2 par_chk, 3 stp_chk, 4 data_valid
   task automatic check_ev(input int kind);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event kind=%0d cyc=%0d (none expected)", kind, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.at != cyc || (e.edge_v >= 0 && e.edge_v != int'(edge_cnt)) ||
             (e.bit_v >= 0 && e.bit_v != int'(bit_cnt)) || e.samp != int'(dat_samp_en)) begin
            errors++;
            $display("FAIL event got kind=%0d cyc=%0d edge=%0d bit=%0d samp=%0b need kind=%0d cyc=%0d edge=%0d bit=%0d samp=%0d",
                     kind, cyc, edge_cnt, bit_cnt, dat_samp_en, e.kind, e.at, e.edge_v, e.bit_v, e.samp);
         end
      end
   endtask

   always @(negedge clk) begin
      if (strt_chk_en === 1'b1) check_ev(0);
      if (deser_en    === 1'b1) check_ev(1);
      if (par_chk_en  === 1'b1) check_ev(2);
      if (stp_chk_en  === 1'b1) check_ev(3);
      if (data_valid  === 1'b1) check_ev(4);
   end

   task automatic chk_zero(input string name);
      logic [14:0] v;
      v = {edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid};
      checks++;
      if (v !== 15'd0) begin
         errors++;
         $display("FAIL %s outputs=%h need 0000", name, v);
      end
   endtask

   task automatic idle(input int k);
      repeat (k) begin @(posedge clk); #1; end
      strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
   endtask

   // p: effective prescale; smode 0 clean, 1 stop error at strobe, 2 stp_err only during data bits
   task automatic frame(input int p, input logic [4:0] p_in, input logic [4:0] p_mid, input logic [7:0] d,
                        input logic pe, input logic perr, input int smode, input int lat);
      int   s, sb;
      logic b;
      s  = cyc + 1;
      sb = pe ? 10 : 9;
      expect_ev(0, s + p, p, 0, 1);
      for (int k = 1; k <= 8; k++) expect_ev(1, s + k * (p + 1) + p, p, k, 1);
      if (pe) expect_ev(2, s + 9 * (p + 1) + p, p, 9, 1);
      if (!(pe && perr)) begin
         expect_ev(3, s + sb * (p + 1) + p, p, sb, 1);
         if (smode != 1) expect_ev(4, cyc + lat, -1, -1, 0);
      end
      prescale = p_in; par_en = pe; par_err = perr; stp_err = (smode == 1);
      for (int k = 0; k <= sb; k++) begin
         if (k == 0)      b = 1'b0;
         else if (k <= 8) b = d[k-1];
         else             b = 1'b1;
         rx_in = b;
         if (k == 3) prescale = p_mid;
         if (smode == 2) stp_err = (k >= 1 && k <= 8);
         repeat (p + 1) begin @(posedge clk); #1; end
      end
      rx_in = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d need completion", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; rx_in = 1'b0; par_en = 1'b0; prescale = 5'd7;
      strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
      // reset held with the line low: nothing may start
      repeat (5) begin @(negedge clk); chk_zero("reset_hold"); end
      rx_in = 1'b1;
      @(posedge clk); #1; rst = 1'b1;
      idle(3);

      // start glitch: strobe at edge 7 of bit 0, then back to idle
      prescale = 5'd7; strt_glitch = 1'b1; rx_in = 1'b0;
      expect_ev(0, cyc + 1 + 7, 7, 0, 1);
      @(posedge clk); #1; rx_in = 1'b1;
      idle(12);

      // P=15, no parity, 0xA5; par_err held high is ignored without a parity strobe
      frame(15, 5'd15, 5'd15, 8'hA5, 1'b0, 1'b1, 0, 161);
      idle(4);

      // P=31, parity error aborts the frame
      frame(31, 5'd31, 5'd31, 8'h3C, 1'b1, 1'b1, 0, 0);
      idle(4);
`ifdef UART_RX_ERR_CNT_EN
      checks++;
      if (par_err_cnt !== 8'd1 || stp_err_cnt !== 8'd0) begin
         errors++;
         $display("FAIL par_err_cnt got par=%0d stp=%0d need par=1 stp=0", par_err_cnt, stp_err_cnt);
      end
`endif

      // back-to-back frames at P=7; stp_err outside its strobe is ignored
      frame(7, 5'd7, 5'd7, 8'h12, 1'b0, 1'b0, 2, 81);
      frame(7, 5'd7, 5'd7, 8'hED, 1'b0, 1'b0, 0, 81);
      idle(4);

      // prescale change mid-frame ignored; illegal prescale behaves as 7
      frame(7, 5'd7, 5'd31, 8'h5A, 1'b0, 1'b0, 0, 81);
      idle(4);
      frame(7, 5'd9, 5'd9, 8'hC3, 1'b0, 1'b0, 0, 81);
      idle(4);

      // clean parity frame at P=7, then a stop error
      frame(7, 5'd7, 5'd7, 8'h0F, 1'b1, 1'b0, 0, 89);
      idle(4);
      frame(7, 5'd7, 5'd7, 8'hFF, 1'b0, 1'b0, 1, 0);
      idle(4);
`ifdef UART_RX_ERR_CNT_EN
      checks++;
      if (par_err_cnt !== 8'd1 || stp_err_cnt !== 8'd1) begin
         errors++;
         $display("FAIL stp_err_cnt got par=%0d stp=%0d need par=1 stp=1", par_err_cnt, stp_err_cnt);
      end
`endif

      // reset in the middle of data bit 3 aborts with no data_valid
      prescale = 5'd7; par_en = 1'b0;
      expect_ev(0, cyc + 8, 7, 0, 1);
      expect_ev(1, cyc + 16, 7, 1, 1);
      expect_ev(1, cyc + 24, 7, 2, 1);
      rx_in = 1'b0;
      repeat (28) begin @(posedge clk); #1; end
      rst = 1'b0; rx_in = 1'b1;
      @(negedge clk); chk_zero("mid_frame_reset");
      @(posedge clk); #1; rst = 1'b1;
      idle(12);
      @(negedge clk); chk_zero("idle_after_abort");

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_events got %0d left need 0 (next kind=%0d at=%0d)",
                  exp_q.size(), exp_q[0].kind, exp_q[0].at);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
